// File: rtl/word_count_accum.sv
// Purpose: per-entry count + last key table fed by the accum write stream, dumped (and cleared) on dump_kick.
// Latency: entry is updated at the end of the cycle after accum_we; a dump costs 1 + 2 cycles per entry (+ stalls).
// Backpressure: none on the accum stream (writes outside IDLE or out of range are dropped and counted); dump beats hold on out_ready.
//
// Ports: clk/reset (async, active-high); ready = table initialised; accum_addr/accum_din/accum_we = write stream
// ({key, increment}); dump_kick starts a dump, busy covers it, dump_done pulses at its end; out_valid/out_ready
// with out_addr/out_key_value/out_count carry the non-zero entries; drop_cnt counts dropped writes (saturating).
// Build option: define WORD_COUNT_ACCUM_SAT_EN to make counts saturate at 2^CNT_W-1 instead of wrapping.
module word_count_accum #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic [31:0]       accum_addr,
    input  logic [63:0]       accum_din,
    input  logic              accum_we,
    input  logic              dump_kick,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_key_value,
    output logic [CNT_W-1:0]  out_count,
    output logic              dump_done,
    output logic [15:0]       drop_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ENT_W = 32 + CNT_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
`ifdef WORD_COUNT_ACCUM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {INIT_CLR, IDLE, DRAIN, DUMP_RD, DUMP_CHK} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              done_nxt;

    // Table storage: entry = {key[31:0], count[CNT_W-1:0]}; read-first, registered read data.
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [ENT_W-1:0]  mem_wd;
    logic [CNT_W-1:0]  rd_cnt;

    // S1: the write whose RAM read is in flight; it commits in the following cycle.
    logic              s1_vld, s1_byp;
    logic [ADDR_W-1:0] s1_addr;
    logic [31:0]       s1_key;
    logic [CNT_W-1:0]  s1_inc, s1_byp_cnt, s1_old, s1_sum;
    logic [CNT_W:0]    s1_add;

    logic              addr_ok, accept, drop;

    assign rd_cnt  = rd_data[CNT_W-1:0];
    assign addr_ok = (accum_addr >> ADDR_W) == 32'd0;
    assign accept  = accum_we && addr_ok && (state == IDLE);
    assign drop    = accum_we && !accept;

    // The RAM read for S1 was issued while the previous write was still committing, so a same-index
    // predecessor is taken from its captured sum instead of the stale read data.
    assign s1_old = s1_byp ? s1_byp_cnt : rd_cnt;
    assign s1_add = {1'b0, s1_old} + {1'b0, s1_inc};
    assign s1_sum = (SAT_EN && s1_add[CNT_W]) ? {CNT_W{1'b1}} : s1_add[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT_CLR;
            idx       <= '0;
            dump_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dump_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        rd_addr   = idx;
        mem_we    = 1'b0;
        mem_wa    = idx;
        mem_wd    = '0;
        case (state)
            INIT_CLR: begin
                mem_we = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            IDLE: begin
                rd_addr = accum_addr[ADDR_W-1:0];
                if (dump_kick) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DUMP_RD;
                idx_nxt   = '0;
            end
            DUMP_RD: state_nxt = DUMP_CHK;
            DUMP_CHK: begin
                // rd_addr stays on idx, so the beat is re-read unchanged while stalled.
                if (rd_cnt == '0 || out_ready) begin
                    mem_we = (rd_cnt != '0);
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DUMP_RD;
                        idx_nxt   = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = INIT_CLR;
        endcase
        // S1 only exists in IDLE/DRAIN, where no other write is pending.
        if (s1_vld) begin
            mem_we = 1'b1;
            mem_wa = s1_addr;
            mem_wd = {s1_key, s1_sum};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld     <= 1'b0;
            s1_byp     <= 1'b0;
            s1_addr    <= '0;
            s1_key     <= '0;
            s1_inc     <= '0;
            s1_byp_cnt <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_byp     <= s1_vld && (s1_addr == accum_addr[ADDR_W-1:0]);
                s1_byp_cnt <= s1_sum;
                s1_addr    <= accum_addr[ADDR_W-1:0];
                s1_key     <= accum_din[63:32];
                s1_inc     <= accum_din[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign ready         = (state != INIT_CLR);
    assign busy          = (state == DRAIN) || (state == DUMP_RD) || (state == DUMP_CHK);
    assign out_valid     = (state == DUMP_CHK) && (rd_cnt != '0);
    assign out_addr      = idx;
    assign out_key_value = rd_data[ENT_W-1:CNT_W];
    assign out_count     = rd_cnt;
endmodule

// File: tb/tb_word_count_accum.sv
// Self-checking bench for word_count_accum: reset/init timing, hand-written RMW, hazard and stall
// sequences, a table of write vectors with drop checks, randomized rounds against a table model,
// a mid-dump reset, and a CNT_W=4 instance for saturate/wrap behaviour.
module tb_word_count_accum;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        ready, busy, out_valid, out_ready, dump_done, accum_we, dump_kick;
    logic [31:0] accum_addr, out_key_value, out_count;
    logic [63:0] accum_din;
    logic [9:0]  out_addr;
    logic [15:0] drop_cnt;

    logic        ready4, busy4, out_valid4, out_ready4, dump_done4, accum_we4, dump_kick4;
    logic [31:0] accum_addr4, out_key4;
    logic [63:0] accum_din4;
    logic [2:0]  out_addr4;
    logic [3:0]  out_count4;
    logic [15:0] drop_cnt4;

    word_count_accum #(.ADDR_W(10), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ready(ready), .accum_addr(accum_addr), .accum_din(accum_din),
        .accum_we(accum_we), .dump_kick(dump_kick), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_key_value(out_key_value),
        .out_count(out_count), .dump_done(dump_done), .drop_cnt(drop_cnt)
    );

    word_count_accum #(.ADDR_W(3), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ready(ready4), .accum_addr(accum_addr4), .accum_din(accum_din4),
        .accum_we(accum_we4), .dump_kick(dump_kick4), .busy(busy4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_addr(out_addr4), .out_key_value(out_key4),
        .out_count(out_count4), .dump_done(dump_done4), .drop_cnt(drop_cnt4)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the table as plain arrays plus the expected drop total.
    logic [31:0] mcnt [DEPTH];
    logic [31:0] mkey [DEPTH];
    int          exp_drop;

    logic [9:0]  b_addr [$];
    logic [31:0] b_key  [$];
    logic [31:0] b_cnt  [$];
    bit          rdy_rand;
    bit          inj_busy_we;
    int          busy_cyc;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] din;
        int          drop_rel;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] add_cnt(input logic [31:0] o, input logic [31:0] inc);
        logic [63:0] s;
        s = 64'(o) + 64'(inc);
`ifdef WORD_COUNT_ACCUM_SAT_EN
        if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    function automatic void model_apply(input logic [31:0] a, input logic [63:0] d);
        if (a < DEPTH) begin
            mcnt[a[9:0]] = add_cnt(mcnt[a[9:0]], d[31:0]);
            mkey[a[9:0]] = d[63:32];
        end else begin
            exp_drop++;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mcnt[i] = '0;
            mkey[i] = '0;
        end
    endfunction

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        accum_we   = 1'b1;
        accum_addr = a;
        accum_din  = d;
        model_apply(a, d);
        step();
    endtask

    task automatic do_dump();
        bit got_done, prev_stall;
        logic [73:0] snap;
        b_addr.delete(); b_key.delete(); b_cnt.delete();
        got_done = 0; prev_stall = 0; busy_cyc = 0; snap = '0;
        dump_kick = 1'b1;
        step();
        dump_kick = 1'b0;
        accum_we  = 1'b0;
        chk("busy_rise", busy, 1);
        for (int c = 0; c < 8000; c++) begin
            if (dump_done) begin
                got_done = 1;
                break;
            end
            if (busy) busy_cyc++;
            if (prev_stall)
                chk("beat_hold", {out_valid, out_addr, out_key_value, out_count}, {1'b1, snap});
            out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                b_addr.push_back(out_addr);
                b_key.push_back(out_key_value);
                b_cnt.push_back(out_count);
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_addr, out_key_value, out_count};
            if (inj_busy_we && c == 7) begin
                accum_we = 1'b1; accum_addr = 32'd3; accum_din = {32'hDEAD0000, 32'd9};
                exp_drop++;
            end else begin
                accum_we = 1'b0;
            end
            step();
        end
        chk("dump_done_seen", got_done, 1);
        chk("busy_fall", busy, 0);
        out_ready = 1'b1;
        step();
        chk("done_pulse", dump_done, 0);
    endtask

    task automatic compare_model();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mcnt[i] != 0) begin
                if (n < b_addr.size())
                    chk("beat", {b_addr[n], b_key[n], b_cnt[n]}, {10'(i), mkey[i], mcnt[i]});
                n++;
                mcnt[i] = '0;
                mkey[i] = '0;
            end
        end
        chk("beat_count", b_addr.size(), n);
    endtask

    task automatic wait_ready(input string name);
        int cyc;
        cyc = 0;
        while (!ready && cyc < 3000) begin
            step();
            cyc++;
        end
        chk(name, cyc, DEPTH);
    endtask

    initial begin
        logic [31:0] a, inc;
        logic [63:0] d;
        int base, n4, c;
        bit got;
        logic [3:0] c4;
        logic [2:0] a4;
        logic [31:0] k4;

        vt[0] = '{32'h0000_0000, {32'h0000_0011, 32'd1},          0};
        vt[1] = '{32'h0000_03FF, {32'h0000_0022, 32'd5},          0};
        vt[2] = '{32'h0000_0400, {32'h0000_0033, 32'd1},          1};
        vt[3] = '{32'h0000_03FF, {32'h0000_0044, 32'd7},          1};
        vt[4] = '{32'h8000_0000, {32'h0000_0055, 32'd1},          2};
        vt[5] = '{32'h0000_0010, {32'h0000_0066, 32'hFFFF_FFFF},  2};
        vt[6] = '{32'h0000_0010, {32'h0000_0077, 32'd2},          2};
        vt[7] = '{32'h0000_0000, {32'h0000_0088, 32'd3},          2};

        model_clear();
        exp_drop = 0; rdy_rand = 0; inj_busy_we = 0;
        accum_we = 0; accum_addr = 0; accum_din = 0; dump_kick = 0; out_ready = 1;
        accum_we4 = 0; accum_addr4 = 0; accum_din4 = 0; dump_kick4 = 0; out_ready4 = 1;
        reset = 1'b0;
        #1 reset = 1'b1;
        #11;
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_outs", {out_addr, out_key_value, out_count}, 0);
        chk("rst_drop", drop_cnt, 0);
        step();
        reset = 1'b0;
        wait_ready("init_cycles");

        // CNT_W=4 instance: 17 back-to-back increments of 1 to entry 0.
        chk("sat_ready", ready4, 1);
        accum_we4 = 1; accum_addr4 = 0; accum_din4 = {32'hBEEF0000, 32'd1};
        repeat (17) step();
        accum_we4 = 0;
        dump_kick4 = 1;
        step();
        dump_kick4 = 0;
        n4 = 0; got = 0; c4 = 0; a4 = 0; k4 = 0;
        for (int i = 0; i < 200; i++) begin
            if (dump_done4) begin
                got = 1;
                break;
            end
            if (out_valid4) begin
                n4++; c4 = out_count4; a4 = out_addr4; k4 = out_key4;
            end
            step();
        end
        chk("sat_done", got, 1);
        chk("sat_beats", n4, 1);
`ifdef WORD_COUNT_ACCUM_SAT_EN
        chk("sat_count", c4, 15);
`else
        chk("wrap_count", c4, 1);
`endif
        chk("sat_beat_id", {a4, k4}, {3'd0, 32'hBEEF0000});

        // Empty table dump.
        do_dump();
        chk("empty_beats", b_addr.size(), 0);
        chk("empty_busy", busy_cyc, 2049);

        // Three back-to-back writes to entry 5 exercise the bypass twice.
        for (int i = 0; i < 3; i++) wr(32'd5, 64'hAAAA0001_00000001);
        accum_we = 0;
        do_dump();
        chk("rmw3_beats", b_addr.size(), 1);
        if (b_addr.size() > 0) chk("rmw3_beat", {b_addr[0], b_key[0], b_cnt[0]}, {10'd5, 32'hAAAA0001, 32'd3});
        chk("rmw3_busy", busy_cyc, 2049);
        compare_model();

        // 5, 6, 5: bypass must not fire across a different index.
        wr(32'd5, {32'h5, 32'd1});
        wr(32'd6, {32'h6, 32'd1});
        wr(32'd5, {32'h5, 32'd1});
        accum_we = 0;
        do_dump();
        chk("alt_beats", b_addr.size(), 2);
        if (b_addr.size() > 1) begin
            chk("alt_beat0", {b_addr[0], b_cnt[0]}, {10'd5, 32'd2});
            chk("alt_beat1", {b_addr[1], b_cnt[1]}, {10'd6, 32'd1});
        end
        compare_model();

        // Stall a beat for 10 cycles, then dump again: nothing left.
        wr(32'd9, {32'h12345678, 32'd4});
        accum_we = 0;
        out_ready = 0;
        dump_kick = 1;
        step();
        dump_kick = 0;
        c = 0;
        while (!out_valid && c < 100) begin
            step();
            c++;
        end
        chk("stall_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {out_valid, out_addr, out_key_value, out_count}, {1'b1, 10'd9, 32'h12345678, 32'd4});
            step();
        end
        out_ready = 1;
        c = 0;
        while (!dump_done && c < 3000) begin
            step();
            c++;
        end
        chk("stall_done", dump_done, 1);
        model_clear();
        do_dump();
        chk("redump_beats", b_addr.size(), 0);

        // Table vectors: drops by high address bits, aliasing, wrap/saturate with bypass.
        base = exp_drop;
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].addr, vt[i].din);
            chk($sformatf("vec%0d_drop", i), drop_cnt, base + vt[i].drop_rel);
        end
        accum_we = 0;
        inj_busy_we = 1;
        do_dump();
        inj_busy_we = 0;
        compare_model();
        chk("drop_total", drop_cnt, exp_drop);

        // Randomized rounds; the dump kick carries a write of its own.
        rdy_rand = 1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    accum_we = 0;
                    step();
                end else begin
                    c = $urandom_range(0, 9);
                    if (c < 6)      a = $urandom_range(0, 7);
                    else if (c < 9) a = $urandom_range(0, DEPTH - 1);
                    else            a = 32'h400 + $urandom_range(0, 1 << 20);
                    inc = ($urandom_range(0, 4) == 0) ? $urandom() : $urandom_range(1, 5);
                    wr(a, {$urandom(), inc});
                end
            end
            a = $urandom_range(0, 15);
            d = {$urandom(), 32'($urandom_range(1, 9))};
            accum_we = 1; accum_addr = a; accum_din = d;
            model_apply(a, d);
            do_dump();
            compare_model();
            chk("rand_drop", drop_cnt, exp_drop);
        end
        rdy_rand = 0;

        // Reset in the middle of a stalled dump: back to INIT_CLR, table re-cleared.
        wr(32'd2, {32'h2, 32'd1});
        wr(32'd700, {32'h700, 32'd1});
        accum_we = 0;
        out_ready = 0;
        dump_kick = 1;
        step();
        dump_kick = 0;
        repeat (50) step();
        reset = 1;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        step();
        reset = 0;
        out_ready = 1;
        model_clear();
        exp_drop = 0;
        wait_ready("reinit_cycles");
        do_dump();
        chk("post_rst_beats", b_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/word_count_accum.md
# word_count_accum

Count-table responder for the word-count datapath. It sits at the far end of the `accum_addr`/`accum_din`/`accum_we` write stream produced by the search-and-add stage and keeps a per-entry count plus the last key value for each Axonerve entry address. It updates the table with a single-cycle read-modify-write (RMW) pipeline that bypasses back-to-back same-address hazards. On `dump_kick` it streams every non-zero entry to the host over a valid/ready port, clearing each entry as it is consumed.

## Interface
Parameters:
- `ADDR_W`, default 10: table index width; DEPTH = 2^ADDR_W entries.
- `CNT_W`, default 32: count width, 1..32.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ready` out 1: table is initialised and accepts writes.
- `accum_addr` in 32: entry address. Only bits [ADDR_W-1:0] index the table.
- `accum_din` in 64: [63:32] key value, [31:0] increment (only the low CNT_W bits are used).
- `accum_we` in 1: write strobe. There is no backpressure.
- `dump_kick` in 1: one-cycle request to start a dump.
- `busy` out 1: a dump is in progress (DRAIN, DUMP_RD or DUMP_CHK).
- `out_valid` out 1: dump beat is valid.
- `out_ready` in 1: consumer accepts the dump beat.
- `out_addr` out ADDR_W: entry index of the beat.
- `out_key_value` out 32: stored key value of the beat.
- `out_count` out CNT_W: stored count of the beat.
- `dump_done` out 1: one-cycle pulse when a dump finishes.
- `drop_cnt` out 16: number of dropped writes; saturates at 0xFFFF.

## Operation
- Storage is one RAM of DEPTH × (32 + CNT_W) bits with synchronous read-first behaviour, 1-cycle read latency and a single port.
- The state machine has five states: INIT_CLR, IDLE, DRAIN, DUMP_RD, DUMP_CHK.
- INIT_CLR:
  - Entered on reset.
  - Writes zero to index 0..DEPTH-1, one entry per cycle.
  - Goes to IDLE after the last index.
  - `ready`=0 while in this state; `ready`=1 in every other state.
- IDLE, accum path:
  - An accepted `accum_we` issues a read of the addressed entry in the same cycle and loads stage S1.
  - In the next cycle S1 computes new count = old count + increment and new key = din[63:32], and writes the entry.
  - Hazard: if S1 holds the same index as the current accepted write, the RMW uses S1's sum instead of the stale RAM read. The bypass depth is 1.
- A write is dropped (no table change, `drop_cnt`+1) in either case:
  - accum_addr[31:ADDR_W] is non-zero.
  - `accum_we` arrives in any state other than IDLE.
- `dump_kick` in IDLE:
  - The write accepted in the same cycle, if any, is still processed.
  - Next state is DRAIN, which lasts 1 cycle and commits S1.
  - Then DUMP_RD starts at index 0.
- `dump_kick` outside IDLE is ignored.
- DUMP_RD: reads the current index, then goes to DUMP_CHK.
- DUMP_CHK:
  - Count == 0: if index == DEPTH-1, pulse `dump_done` and go to IDLE; otherwise increment the index and go to DUMP_RD.
  - Count != 0: present the beat and hold it until `out_valid && out_ready`. On the handshake, write the entry to zero, then finish or advance exactly as in the zero case.
- Key value is always overwritten with the most recent write's key value.

## Timing
- Reset values: `ready`, `busy`, `out_valid`, `dump_done`, `out_addr`, `out_key_value`, `out_count` and `drop_cnt` are all 0.
- Assertion of `reset`, at any time including mid-dump, returns to INIT_CLR. The table is re-cleared and S1 is discarded.
- `ready` rises exactly DEPTH cycles after `reset` deasserts.
- Write latency: the entry is updated at the end of the cycle after `accum_we`. A dump observes it because of the DRAIN cycle.
- Accum throughput is one write per cycle with no stall.
- Dump timing:
  - A zero entry costs 2 cycles.
  - A non-zero entry costs 2 cycles plus any `out_ready` stall.
- `out_*` are registered and remain stable while `out_valid`=1 and `out_ready`=0.
- `busy` rises the cycle after `dump_kick` and falls in the same cycle `dump_done` pulses.

## Configuration
- `WORD_COUNT_ACCUM_SAT_EN` defined: the count saturates at 2^CNT_W-1.
- Not defined: the count wraps modulo 2^CNT_W.

## Test plan
- Reset with ADDR_W=10 → `ready`=0 for 1024 cycles, then `ready`=1. A dump then produces no beats, a single `dump_done` pulse, and `busy` for 2049 cycles (DRAIN plus 2 × 1024).
- Three back-to-back writes to addr 5 with din=0xAAAA0001_00000001, then a dump → exactly one beat: addr 5, key 0xAAAA0001, count 3.
- Consecutive writes to addr 5, 6, 5 (increment 1) → beats (5, count 2) then (6, count 1), in index order.
- Hold `out_ready`=0 for 10 cycles during a beat → `out_*` stay stable. Dump again immediately → no beats, because the entries were cleared by the first dump.
- CNT_W=4, 17 writes of increment 1 to addr 0 → count 15 with `WORD_COUNT_ACCUM_SAT_EN` defined, count 1 without it.
- Write to addr 0x400 with ADDR_W=10, plus one `accum_we` while `busy` → `drop_cnt`=2 and no table change.
